sensor_conditioner: RTL
=======================

Name: sensor_conditioner

Overview:
- Input-side stage for the tank/irrigation sensor path.
- Synchronizes and debounces the raw level and auxiliary sensor lines, then presents glitch-free registered status flags to the status-display segment decoder.
- Also detects physically impossible level-sensor combinations and latches a fault flag.
- Sits between the board sensor pins and the display decoder.

Parameters:
- N_CH, 5, number of sensor channels. Bits 0..2 are level sensors (low, mid, high); the remaining bits are auxiliary and get no consistency check.
- TICK_DIV, 50000, clocks per sample tick (minimum 2).
- DEB_COUNT, 4, consecutive differing sample ticks required to flip a stable bit (minimum 1).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sens_raw  input  N_CH  raw asynchronous sensor lines, 1 = wet/active
- clr_err  input  1  synchronous clear of the latched fault
- sens_stable  output  N_CH  debounced registered flags, fed to the display decoder
- sens_chg  output  1  one-cycle pulse when any sens_stable bit changed
- sens_err  output  1  sticky level-inconsistency fault
- tick  output  1  one-cycle sample strobe, exported for neighbouring stages

Behaviour:
- Clocking and reset:
  - Single clock domain: clk.
  - rst_n is asynchronous, active-low.
  - Reset values: sens_stable=0, sens_chg=0, sens_err=0, tick=0; synchronizer flops, prescaler and all debounce counters = 0.
  - Reset asserted mid-debounce discards partial counts. No output glitches to 1 during reset.
- Synchronizer:
  - 2-flop synchronizer per channel; sync = second flop.
  - A raw change reaches sync after 2 clk.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick=1 for exactly the cycle where count == TICK_DIV-1.
  - First tick occurs TICK_DIV clocks after reset release.
- Debounce, per channel i, evaluated only on tick cycles:
  - If sync[i] == sens_stable[i], cnt[i] <= 0.
  - Else if cnt[i] == DEB_COUNT-1, sens_stable[i] toggles and cnt[i] <= 0.
  - Else cnt[i] <= cnt[i]+1.
  - A single matching sample resets the count, so bounce shorter than DEB_COUNT ticks is rejected.
  - sens_stable updates on the clock edge ending the qualifying tick cycle.
  - Counter width is clog2(DEB_COUNT), minimum 1. It never exceeds DEB_COUNT-1.
- Change strobe:
  - sens_chg=1 in the cycle immediately after any sens_stable bit flips, for exactly 1 clk.
  - Multiple channels flipping on the same tick produce a single pulse.
- Fault detection is combinational on sens_stable:
  - bad = (high & ~mid) | (high & ~low) | (mid & ~low).
  - When bad is 1, sens_err <= 1 on the next edge.
  - sens_err then holds until a clr_err cycle with bad==0.
  - clr_err asserted together with bad==1: set wins, and sens_err stays 1.
  - clr_err with sens_err already 0: no effect.
- Outside tick cycles, sens_stable is held; sens_raw has no effect except through the synchronizer.

Decomposition:
- Shared package sensor_pkg holds:
  - Channel index constants: CH_LOW=0, CH_MID=1, CH_HIGH=2, CH_AUX0=3, CH_AUX1=4.
  - Default TICK_DIV and DEB_COUNT.
  - A function level_bad(low, mid, high) reused by the display path.
- One natural sub-module, debounce_ch: a single-channel synchronizer plus counter, with tick input, stable output and a flip pulse. It is instantiated N_CH times via generate.
- The prescaler, change-OR and fault latch stay in the top module.

Test Plan (bench uses TICK_DIV=4, DEB_COUNT=3):
- Reset release, all inputs 0: first tick at clk 4 after release, then every 4 clocks; sens_stable=5'b00000; sens_chg and sens_err never assert.
- sens_raw[0] held 1 from clk 0: sens_stable[0] rises after the 3rd qualifying tick, about 12 clocks after sync; sens_chg pulses exactly once, 1 cycle later.
- Bounce: sens_raw[1] at 1 for 2 ticks, 0 for 1 tick, 1 for 2 ticks: sens_stable[1] stays 0; no sens_chg pulse.
- Inconsistency: drive sens_raw=5'b00100 (high only) and let it settle: sens_err=1 one cycle after sens_stable[2] rises. clr_err pulsed while still bad leaves sens_err=1. Set sens_raw=5'b00111, settle, then pulse clr_err: sens_err=0.
- Simultaneous flip: sens_raw 5'b00000 -> 5'b11000 in one step: both bits rise on the same tick; sens_chg is a single 1-cycle pulse.
- Assert rst_n=0 for 1 clk mid-debounce (count=2) on channel 3: all outputs 0 immediately. After release, the channel needs a full 3 new ticks to flip.

Source files
------------

// File: rtl/sensor_pkg.sv
// rtl/sensor_pkg.sv - shared constants and level-consistency helper for the sensor path
package sensor_pkg;

    localparam int CH_LOW  = 0;
    localparam int CH_MID  = 1;
    localparam int CH_HIGH = 2;
    localparam int CH_AUX0 = 3;
    localparam int CH_AUX1 = 4;

    localparam int DEF_TICK_DIV  = 50000;
    localparam int DEF_DEB_COUNT = 4;

    // A wet upper sensor with a dry lower one cannot happen in a real tank.
    function automatic logic level_bad(input logic low, input logic mid, input logic high);
        return (high & ~mid) | (high & ~low) | (mid & ~low);
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// rtl/debounce_ch.sv - single-channel synchronizer and tick-driven debounce counter
module debounce_ch
    import sensor_pkg::*;
#(
    parameter int DEB_COUNT = DEF_DEB_COUNT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    input  logic tick,
    output logic stable_out,
    output logic flip
);

    localparam int CW = (DEB_COUNT > 1) ? $clog2(DEB_COUNT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_COUNT - 1);

    logic          meta_q;
    logic          sync_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= raw_in;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Any matching sample restarts the run, so only an unbroken streak flips.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        flip     = 1'b0;
        if (tick) begin
            if (sync_q == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
                stable_d = ~stable_q;
                cnt_d    = '0;
                flip     = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign stable_out = stable_q;

endmodule

// File: rtl/sensor_conditioner.sv
// rtl/sensor_conditioner.sv - sample prescaler, per-channel debounce, change strobe and level fault latch
module sensor_conditioner
    import sensor_pkg::*;
#(
    parameter int N_CH      = 5,
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int DEB_COUNT = DEF_DEB_COUNT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] sens_raw,
    input  logic            clr_err,
    output logic [N_CH-1:0] sens_stable,
    output logic            sens_chg,
    output logic            sens_err,
    output logic            tick
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);

    logic [PW-1:0]   presc_q, presc_d;
    logic            chg_q, chg_d;
    logic            err_q, err_d;
    logic [N_CH-1:0] flip_vec;
    logic            bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            chg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            chg_q   <= chg_d;
            err_q   <= err_d;
        end
    end

    assign tick = (presc_q == PRESC_TOP);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_ch #(
            .DEB_COUNT (DEB_COUNT)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .raw_in     (sens_raw[g]),
            .tick       (tick),
            .stable_out (sens_stable[g]),
            .flip       (flip_vec[g])
        );
    end

    assign bad = level_bad(sens_stable[CH_LOW], sens_stable[CH_MID], sens_stable[CH_HIGH]);

    // Set dominates clear so a fault cannot be acknowledged while still present.
    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        chg_d   = |flip_vec;
        err_d   = err_q;
        if (bad) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end
    end

    assign sens_chg = chg_q;
    assign sens_err = err_q;

endmodule
